// File: rtl/biriscv_csr_issue_ctrl.sv
// Serialising issue controller for the shared CSR/system unit: grants one system op at a time,
// strobes the CSR unit once per op, and holds off further issue until writeback plus fence drain.
module biriscv_csr_issue_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int DRAIN_W      = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    input  logic [31:0] req0_opcode_i,
    input  logic [31:0] req0_pc_i,
    input  logic [31:0] req0_ra_operand_i,
    input  logic        req1_valid_i,
    input  logic [31:0] req1_opcode_i,
    input  logic [31:0] req1_pc_i,
    input  logic [31:0] req1_ra_operand_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        wb_done_i,
    output logic        grant0_o,
    output logic        grant1_o,
    output logic        opcode_valid_o,
    output logic [31:0] opcode_opcode_o,
    output logic [31:0] opcode_pc_o,
    output logic [31:0] opcode_ra_operand_o,
    output logic        busy_o,
    output logic        interrupt_inhibit_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic               HAS_DRAIN  = (DRAIN_CYCLES > 0);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    state_t             state_q, state_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [31:0]        opcode_q, pc_q, ra_q;
    logic               fence_q;

    logic               can_grant;
    logic               grant_any;
    logic [31:0]        sel_opcode, sel_pc, sel_ra;

    // Ops that change memory ordering or translation need the pipe to settle after retire.
    function automatic logic is_fence_class(input logic [31:0] op);
        logic [2:0] f3;
        logic       sys;
        logic       csr_wr;
        f3     = op[14:12];
        sys    = (op[6:0] == 7'b1110011);
        csr_wr = (f3 == 3'b001) || (f3 == 3'b101) ||
                 (((f3 == 3'b010) || (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111)) &&
                  (op[19:15] != 5'd0));
        is_fence_class = (op[6:0] == 7'b0001111) ||
                         (sys && (f3 == 3'b000) && (op[31:25] == 7'b0001001)) ||
                         (sys && (op[31:20] == 12'h180) && csr_wr);
    endfunction

    assign can_grant = (state_q == ST_IDLE) & ~stall_i & ~flush_i & ~rst_i;
    assign grant0_o  = can_grant & req0_valid_i;
    assign grant1_o  = can_grant & req1_valid_i & ~req0_valid_i;
    assign grant_any = grant0_o | grant1_o;

    assign sel_opcode = req0_valid_i ? req0_opcode_i     : req1_opcode_i;
    assign sel_pc     = req0_valid_i ? req0_pc_i         : req1_pc_i;
    assign sel_ra     = req0_valid_i ? req0_ra_operand_i : req1_ra_operand_i;

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_any) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (flush_i)       state_d = ST_IDLE;
                else if (!stall_i) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A retire reported in the same cycle as a squash still counts as a retire.
                if (wb_done_i) begin
                    if (fence_q && HAS_DRAIN) begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = DRAIN_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (flush_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == '0) state_d = ST_IDLE;
                else                   drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= '0;
            opcode_q    <= '0;
            pc_q        <= '0;
            ra_q        <= '0;
            fence_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            if (grant_any) begin
                opcode_q <= sel_opcode;
                pc_q     <= sel_pc;
                ra_q     <= sel_ra;
                fence_q  <= is_fence_class(sel_opcode);
            end
        end
    end

    assign opcode_valid_o      = (state_q == ST_ISSUE) & ~stall_i & ~flush_i;
    assign opcode_opcode_o     = opcode_q;
    assign opcode_pc_o         = pc_q;
    assign opcode_ra_operand_o = ra_q;
    assign busy_o              = (state_q != ST_IDLE);
    assign interrupt_inhibit_o = busy_o | req0_valid_i | req1_valid_i;

endmodule

// File: tb/tb_biriscv_csr_issue_ctrl.sv
// Directed bench for the CSR issue controller: inputs change and outputs are sampled on negedges.
module tb_biriscv_csr_issue_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req0_valid_i, req1_valid_i;
    logic [31:0] req0_opcode_i, req0_pc_i, req0_ra_operand_i;
    logic [31:0] req1_opcode_i, req1_pc_i, req1_ra_operand_i;
    logic        stall_i, flush_i, wb_done_i;
    logic        grant0_o, grant1_o, opcode_valid_o, busy_o, interrupt_inhibit_o;
    logic [31:0] opcode_opcode_o, opcode_pc_o, opcode_ra_operand_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    biriscv_csr_issue_ctrl #(.DRAIN_CYCLES(2), .DRAIN_W(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_opcode_i(req0_opcode_i),
        .req0_pc_i(req0_pc_i), .req0_ra_operand_i(req0_ra_operand_i),
        .req1_valid_i(req1_valid_i), .req1_opcode_i(req1_opcode_i),
        .req1_pc_i(req1_pc_i), .req1_ra_operand_i(req1_ra_operand_i),
        .stall_i(stall_i), .flush_i(flush_i), .wb_done_i(wb_done_i),
        .grant0_o(grant0_o), .grant1_o(grant1_o),
        .opcode_valid_o(opcode_valid_o), .opcode_opcode_o(opcode_opcode_o),
        .opcode_pc_o(opcode_pc_o), .opcode_ra_operand_o(opcode_ra_operand_o),
        .busy_o(busy_o), .interrupt_inhibit_o(interrupt_inhibit_o)
    );

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        req0_valid_i = 0; req1_valid_i = 0;
        stall_i = 0; flush_i = 0; wb_done_i = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1; req0_valid_i = 1; req0_opcode_i = 32'h30002373;
        req0_pc_i = 32'h1000; req0_ra_operand_i = 32'h0;
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            checks++;
            if (grant0_o !== 1'b0 || grant1_o !== 1'b0 || opcode_valid_o !== 1'b0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs cyc %0d: g0=%b g1=%b ov=%b busy=%b want all 0",
                         i, grant0_o, grant1_o, opcode_valid_o, busy_o);
            end
        end
        step(); rst_i = 0; #1;
        checks++;
        if (grant0_o !== 1'b1) begin
            errors++; $display("FAIL reset_first_grant got %b want 1", grant0_o);
        end
        step(); req0_valid_i = 0;
        step(); wb_done_i = 1;
        step(); wb_done_i = 0; #1;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL reset_drain_to_idle busy got %b want 0", busy_o);
        end
    endtask

    task automatic test_single_csrrs();
        step(); req0_valid_i = 1; req0_opcode_i = 32'h30002373;
        req0_pc_i = 32'h80000010; req0_ra_operand_i = 32'h00000055; #1;
        checks++;
        if (grant0_o !== 1'b1 || grant1_o !== 1'b0) begin
            errors++; $display("FAIL csrrs_grant g0=%b g1=%b want 1/0", grant0_o, grant1_o);
        end
        step(); req0_valid_i = 0; #1;
        checks++;
        if (opcode_valid_o !== 1'b1 || opcode_opcode_o !== 32'h30002373 ||
            opcode_pc_o !== 32'h80000010 || opcode_ra_operand_o !== 32'h00000055) begin
            errors++;
            $display("FAIL csrrs_issue ov=%b op=%h pc=%h ra=%h want 1 30002373 80000010 00000055",
                     opcode_valid_o, opcode_opcode_o, opcode_pc_o, opcode_ra_operand_o);
        end
        step(); #1;
        checks++;
        if (opcode_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++; $display("FAIL csrrs_wait ov=%b busy=%b want 0 1", opcode_valid_o, busy_o);
        end
        step(); wb_done_i = 1;
        step(); wb_done_i = 0; #1;
        checks++;
        if (busy_o !== 1'b0 || opcode_opcode_o !== 32'h30002373) begin
            errors++; $display("FAIL csrrs_retire busy=%b op=%h want 0 30002373", busy_o, opcode_opcode_o);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        step(); req0_valid_i = 1; req0_opcode_i = 32'h00000073; req0_pc_i = 32'h200;
        req1_valid_i = 1; req1_opcode_i = 32'h34029073; req1_pc_i = 32'h204;
        req1_ra_operand_i = 32'hCAFE0001; #1;
        checks++;
        if (grant0_o !== 1'b1 || grant1_o !== 1'b0) begin
            errors++; $display("FAIL b2b_first g0=%b g1=%b want 1 0", grant0_o, grant1_o);
        end
        for (int c = 1; c <= 7; c++) begin
            step();
            req0_valid_i = 0;
            wb_done_i = (c == 3 || c == 6);
            if (c == 5) req1_valid_i = 0;
            #1;
            if (opcode_valid_o === 1'b1) pulses++;
            if (c == 1 || c == 2 || c == 3) begin
                checks++;
                if (grant1_o !== 1'b0) begin
                    errors++; $display("FAIL b2b_slot1_blocked c%0d got %b want 0", c, grant1_o);
                end
            end
            if (c == 4) begin
                checks++;
                if (grant1_o !== 1'b1) begin
                    errors++; $display("FAIL b2b_slot1_grant got %b want 1", grant1_o);
                end
            end
            if (c == 5) begin
                checks++;
                if (opcode_valid_o !== 1'b1 || opcode_opcode_o !== 32'h34029073 ||
                    opcode_ra_operand_o !== 32'hCAFE0001) begin
                    errors++;
                    $display("FAIL b2b_slot1_issue ov=%b op=%h ra=%h want 1 34029073 cafe0001",
                             opcode_valid_o, opcode_opcode_o, opcode_ra_operand_o);
                end
            end
        end
        wb_done_i = 0;
        checks++;
        if (pulses != 2 || busy_o !== 1'b0) begin
            errors++; $display("FAIL b2b_pulses got %0d busy=%b want 2 0", pulses, busy_o);
        end
    endtask

    // Each entry: opcode and how many extra busy cycles follow its writeback.
    task automatic test_fence_decode();
        logic [31:0] ops [7];
        int          drains [7];
        int          busy_after;
        ops[0] = 32'h18029073; drains[0] = 2;
        ops[1] = 32'h34029073; drains[1] = 0;
        ops[2] = 32'h0000000F; drains[2] = 2;
        ops[3] = 32'h12000073; drains[3] = 2;
        ops[4] = 32'h18002073; drains[4] = 0;
        ops[5] = 32'h18016073; drains[5] = 2;
        ops[6] = 32'h18005073; drains[6] = 2;
        for (int k = 0; k < 7; k++) begin
            step(); req0_valid_i = 1; req0_opcode_i = ops[k];
            step(); req0_valid_i = 0;
            step(); wb_done_i = 1;
            busy_after = 0;
            for (int c = 0; c < 4; c++) begin
                step(); wb_done_i = 0; #1;
                if (busy_o === 1'b1) busy_after++;
            end
            checks++;
            if (busy_after != drains[k]) begin
                errors++;
                $display("FAIL drain_len op=%h got %0d cycles want %0d", ops[k], busy_after, drains[k]);
            end
        end
    endtask

    task automatic test_flush();
        step(); req0_valid_i = 1; req0_opcode_i = 32'h18029073;
        step(); req0_valid_i = 0; flush_i = 1; #1;
        checks++;
        if (opcode_valid_o !== 1'b0) begin
            errors++; $display("FAIL flush_issue ov got %b want 0", opcode_valid_o);
        end
        step(); flush_i = 0; #1;
        checks++;
        if (busy_o !== 1'b0 || opcode_valid_o !== 1'b0) begin
            errors++; $display("FAIL flush_issue_idle busy=%b ov=%b want 0 0", busy_o, opcode_valid_o);
        end
        step(); req0_valid_i = 1;
        step(); req0_valid_i = 0;
        step(); flush_i = 1; wb_done_i = 1;
        step(); flush_i = 0; wb_done_i = 0; #1;
        checks++;
        if (busy_o !== 1'b1) begin
            errors++; $display("FAIL flush_wb_drain1 busy got %b want 1", busy_o);
        end
        step(); flush_i = 1; #1;
        checks++;
        if (busy_o !== 1'b1) begin
            errors++; $display("FAIL flush_wb_drain2 busy got %b want 1", busy_o);
        end
        step(); flush_i = 0; #1;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL flush_wb_drain_end busy got %b want 0", busy_o);
        end
        step(); req0_valid_i = 1;
        step(); req0_valid_i = 0;
        step(); flush_i = 1;
        step(); flush_i = 0; #1;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL flush_wait busy got %b want 0", busy_o);
        end
    endtask

    task automatic test_stall();
        int pulses = 0;
        int inhibit_low = 0;
        step(); stall_i = 1; req0_valid_i = 1; req0_opcode_i = 32'h30002373; #1;
        checks++;
        if (grant0_o !== 1'b0) begin
            errors++; $display("FAIL stall_idle_grant got %b want 0", grant0_o);
        end
        step(); stall_i = 0; #1;
        checks++;
        if (grant0_o !== 1'b1) begin
            errors++; $display("FAIL stall_release_grant got %b want 1", grant0_o);
        end
        for (int c = 0; c < 4; c++) begin
            step(); req0_valid_i = 0; stall_i = 1; #1;
            if (opcode_valid_o === 1'b1) pulses++;
            if (interrupt_inhibit_o !== 1'b1) inhibit_low++;
        end
        checks++;
        if (pulses != 0 || inhibit_low != 0) begin
            errors++; $display("FAIL stall_hold pulses=%0d inh_low=%0d want 0 0", pulses, inhibit_low);
        end
        step(); stall_i = 0; #1;
        checks++;
        if (opcode_valid_o !== 1'b1 || interrupt_inhibit_o !== 1'b1) begin
            errors++; $display("FAIL stall_pulse ov=%b inh=%b want 1 1", opcode_valid_o, interrupt_inhibit_o);
        end
        step(); #1;
        checks++;
        if (opcode_valid_o !== 1'b0 || interrupt_inhibit_o !== 1'b1) begin
            errors++; $display("FAIL stall_single ov=%b inh=%b want 0 1", opcode_valid_o, interrupt_inhibit_o);
        end
        step(); wb_done_i = 1;
        step(); wb_done_i = 0; #1;
        checks++;
        if (busy_o !== 1'b0 || interrupt_inhibit_o !== 1'b0) begin
            errors++; $display("FAIL stall_retire busy=%b inh=%b want 0 0", busy_o, interrupt_inhibit_o);
        end
    endtask

    task automatic test_reset_midop();
        step(); req0_valid_i = 1; req0_opcode_i = 32'h18029073;
        step(); req0_valid_i = 0;
        step(); #2; rst_i = 1; #1;
        checks++;
        if (busy_o !== 1'b0 || opcode_valid_o !== 1'b0 || opcode_opcode_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_midop busy=%b ov=%b op=%h want 0 0 0", busy_o, opcode_valid_o, opcode_opcode_o);
        end
        step(); rst_i = 0;
    endtask

    initial begin
        test_reset();
        test_single_csrrs();
        test_back_to_back();
        test_fence_decode();
        test_flush();
        test_stall();
        test_reset_midop();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
